// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder:
// FSM state encoding, byte-strobe patterns, wait-counter width and the
// store-strobe legality helper used when strobe checking is compiled in.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of the wait-state counter; WAIT_CYCLES is limited to 0..15.
  localparam int CNT_W = 4;

  localparam logic [3:0] STRB_B0  = 4'b0001;
  localparam logic [3:0] STRB_B1  = 4'b0010;
  localparam logic [3:0] STRB_B2  = 4'b0100;
  localparam logic [3:0] STRB_B3  = 4'b1000;
  localparam logic [3:0] STRB_HLO = 4'b0011;
  localparam logic [3:0] STRB_HHI = 4'b1100;
  localparam logic [3:0] STRB_W   = 4'b1111;

  // Single bytes, aligned halves, the full word and the all-zero no-op
  // are the only store strobes MemoryControl is expected to produce.
  function automatic logic strobe_legal(input logic [3:0] strb);
    logic ok;
    ok = 1'b0;
    case (strb)
      4'b0000, STRB_B0, STRB_B1, STRB_B2, STRB_B3,
      STRB_HLO, STRB_HHI, STRB_W: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised synchronous RAM with one byte-wide array per lane, so each
// lane has its own write enable. The read port is registered: data sampled
// on the read-enable edge is held until the next read.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_rd_q;

    // Byte-lane write and registered read; contents are never reset.
    always_ff @(posedge clk) begin
      if (be[gi]) begin
        lane_mem[addr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        lane_rd_q <= lane_mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = lane_rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the MemoryControl memory interface. Accepts one request at a
// time, waits WAIT_CYCLES, then pulses RespValid for one cycle. The RAM
// write/read happens on the edge entering RESP. Out-of-range addresses
// raise RespErr without touching the RAM.
// Build option: define DMEM_STROBE_CHECK_EN to reject irregular store strobes.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [3:0]  Strobe,
  output logic        ReqReady,
  output logic [31:0] RD,
  output logic        RespValid,
  output logic        RespErr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // 33-bit bounds so a window touching the top of the address space cannot wrap.
  localparam logic [32:0] BASE33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT33 = BASE33 + 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wd_q, wd_d;
  logic               we_q, we_d;
  logic [3:0]         strb_q, strb_d;
  logic               err_q, err_d;

  logic [31:0]        cur_addr, cur_wd;
  logic               cur_we;
  logic [3:0]         cur_strb;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_in_range, cur_err;
  logic               commit;
  logic [3:0]         bank_be;
  logic               bank_re;
  logic [31:0]        bank_rd;

  // With zero wait states the commit edge is the accept edge, so the request
  // fields come straight from the inputs while IDLE, else from the latches.
  always_comb begin
    cur_addr = (state_q == IDLE) ? Addr   : addr_q;
    cur_wd   = (state_q == IDLE) ? WD     : wd_q;
    cur_we   = (state_q == IDLE) ? WE     : we_q;
    cur_strb = (state_q == IDLE) ? Strobe : strb_q;
    cur_idx  = IDX_W'((cur_addr - BASE_ADDR) >> 2);
    cur_in_range = ({1'b0, cur_addr} >= BASE33) && ({1'b0, cur_addr} < LIMIT33);
`ifdef DMEM_STROBE_CHECK_EN
    cur_err = !cur_in_range || (cur_we && !strobe_legal(cur_strb));
`else
    cur_err = !cur_in_range;
`endif
  end

  // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    strb_d  = strb_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req) begin
          addr_d = Addr;
          wd_d   = WD;
          we_d   = WE;
          strb_d = Strobe;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = commit ? cur_err : err_q;
  end

  // RAM access only on a commit edge that is not also a reset edge.
  always_comb begin
    bank_be = (commit && rst_n && cur_we && !cur_err) ? cur_strb : 4'b0000;
    bank_re = commit && rst_n && !cur_we;
  end

  // State and request latches; the in-flight request is dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
    end
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk  (clk),
    .addr (cur_idx),
    .be   (bank_be),
    .wdata(cur_wd),
    .re   (bank_re),
    .rdata(bank_rd)
  );

  // Response outputs; RD is forced to zero except for a good load.
  always_comb begin
    ReqReady  = (state_q == IDLE);
    RespValid = (state_q == RESP);
    RespErr   = RespValid && err_q;
    RD        = (RespValid && !we_q && !err_q) ? bank_rd : 32'h0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: requests push expected responses,
// a negedge monitor pops and compares RD, RespErr and response cycle.
// Extra instances with WAIT_CYCLES=0 and 3 check latency and throughput.
module tb_dmem_responder;

  localparam int WAIT_MAIN = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, ready, rv, rerr;
  logic [31:0] addr, wd, rd;
  logic [3:0]  strb;

  logic        r0_req, r0_we, r0_ready, r0_rv, r0_err;
  logic [31:0] r0_addr, r0_wd, r0_rd;
  logic [3:0]  r0_strb;

  logic        r3_req, r3_we, r3_ready, r3_rv, r3_err;
  logic [31:0] r3_addr, r3_wd, r3_rd;
  logic [3:0]  r3_strb;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_MAIN), .BASE_ADDR(32'h0000_2000)) u_dut (
    .clk(clk), .rst_n(rst_n), .Req(req), .Addr(addr), .WD(wd), .WE(we), .Strobe(strb),
    .ReqReady(ready), .RD(rd), .RespValid(rv), .RespErr(rerr)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_2000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .Req(r0_req), .Addr(r0_addr), .WD(r0_wd), .WE(r0_we), .Strobe(r0_strb),
    .ReqReady(r0_ready), .RD(r0_rd), .RespValid(r0_rv), .RespErr(r0_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_2000)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .Req(r3_req), .Addr(r3_addr), .WD(r3_wd), .WE(r3_we), .Strobe(r3_strb),
    .ReqReady(r3_ready), .RD(r3_rd), .RespValid(r3_rv), .RespErr(r3_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every RespValid pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rv) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got RespValid=1 at cyc %0d expected no response", cyc);
      end else begin
        e = sb_q.pop_front();
        $display("resp cyc=%0d rd=%h err=%b", cyc, rd, rerr);
        chk("resp_rd", rd, e.rd);
        chk("resp_err", {31'b0, rerr}, {31'b0, e.err});
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [3:0] s, input logic [31:0] erd, input logic eerr,
                        input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    addr = a; wd = d; we = w; strb = s; req = 1'b1;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ReqReady=0 for 50 cycles expected 1");
      req = 1'b0;
      return;
    end
    if (push) begin
      e.rd  = erd;
      e.err = eerr;
      e.cyc = cyc + 1 + WAIT_MAIN;
      sb_q.push_back(e);
    end
    $display("req cyc=%0d addr=%h wd=%h we=%b strb=%b", cyc + 1, a, d, w, s);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("busy_ready", {31'b0, ready}, 32'h0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d responses missing expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0[$];
    int rsp0[$];
    int acc3, got3;
    logic [31:0] exp_w;

    rst_n = 1'b0;
    req = 0; addr = 0; wd = 0; we = 0; strb = 0;
    r0_req = 0; r0_addr = 0; r0_wd = 0; r0_we = 0; r0_strb = 0;
    r3_req = 0; r3_addr = 0; r3_wd = 0; r3_we = 0; r3_strb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'b0, ready}, 32'h1);
    chk("reset_respvalid", {31'b0, rv}, 32'h0);
    chk("reset_rd", rd, 32'h0);
    chk("reset_resperr", {31'b0, rerr}, 32'h0);

    // Full word store, load back, byte-lane merge, no-op strobe, ignored Addr[1:0].
    do_req(32'h2004, 32'hDEADBEEF, 1, 4'b1111, 32'h0, 0, 1);
    do_req(32'h2004, 32'h0,        0, 4'b0000, 32'hDEADBEEF, 0, 1);
    do_req(32'h2004, 32'h00005500, 1, 4'b0010, 32'h0, 0, 1);
    do_req(32'h2004, 32'h0,        0, 4'b1111, 32'hDEAD55EF, 0, 1);
    do_req(32'h2004, 32'hFFFFFFFF, 1, 4'b0000, 32'h0, 0, 1);
    do_req(32'h2007, 32'h0,        0, 4'b0000, 32'hDEAD55EF, 0, 1);

    // Irregular strobe 0101: rejected with checking, written as given without.
`ifdef DMEM_STROBE_CHECK_EN
    do_req(32'h2004, 32'h11223344, 1, 4'b0101, 32'h0, 1, 1);
    exp_w = 32'hDEAD55EF;
`else
    do_req(32'h2004, 32'h11223344, 1, 4'b0101, 32'h0, 0, 1);
    exp_w = 32'hDE225544;
`endif
    do_req(32'h2004, 32'h0, 0, 4'b0000, exp_w, 0, 1);
    do_req(32'h2004, 32'hAB000000, 1, 4'b1000, 32'h0, 0, 1);
    exp_w = {8'hAB, exp_w[23:0]};
    do_req(32'h2004, 32'h0, 0, 4'b0000, exp_w, 0, 1);

    // Range boundaries: first and last word, then just outside on both sides.
    do_req(32'h2000, 32'h01020304, 1, 4'b1111, 32'h0, 0, 1);
    do_req(32'h2FFC, 32'hA5A5A5A5, 1, 4'b1111, 32'h0, 0, 1);
    do_req(32'h2000, 32'h77770000, 1, 4'b1100, 32'h0, 0, 1);
    do_req(32'h1FFC, 32'hFFFFFFFF, 1, 4'b1111, 32'h0, 1, 1);
    do_req(32'h3000, 32'hEEEEEEEE, 1, 4'b1111, 32'h0, 1, 1);
    do_req(32'h1FFC, 32'h0, 0, 4'b1111, 32'h0, 1, 1);
    do_req(32'h3000, 32'h0, 0, 4'b1111, 32'h0, 1, 1);
    do_req(32'hFFFFFFFC, 32'h0, 0, 4'b1111, 32'h0, 1, 1);
    do_req(32'h2FFC, 32'h0, 0, 4'b1111, 32'hA5A5A5A5, 0, 1);
    do_req(32'h2000, 32'h0, 0, 4'b1111, 32'h77770304, 0, 1);

    // Reset during WAIT of a store: commit edge coincides with rst_n=0.
    do_req(32'h2008, 32'hCAFEF00D, 1, 4'b1111, 32'h0, 0, 1);
    do_req(32'h2008, 32'h12345678, 1, 4'b1111, 32'h0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", {31'b0, ready}, 32'h1);
    chk("abort_respvalid", {31'b0, rv}, 32'h0);
    repeat (4) @(negedge clk);
    do_req(32'h2008, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 0, 1);
    wait_drain();

    // WAIT_CYCLES=0: Req held high for three stores.
    @(negedge clk);
    r0_addr = 32'h2010; r0_wd = 32'h5A5A5A5A; r0_we = 1; r0_strb = 4'b1111; r0_req = 1;
    for (int i = 0; i < 20; i++) begin
      if (r0_rv) begin
        rsp0.push_back(cyc);
        $display("dut0 resp cyc=%0d err=%b", cyc, r0_err);
        chk("dut0_err", {31'b0, r0_err}, 32'h0);
        chk("dut0_rd", r0_rd, 32'h0);
      end
      if (acc0.size() == 3) r0_req = 0;
      if (r0_req && r0_ready) acc0.push_back(cyc + 1);
      @(negedge clk);
    end
    r0_req = 0;
    chk("dut0_accepts", 32'(acc0.size()), 32'd3);
    chk("dut0_resps", 32'(rsp0.size()), 32'd3);
    for (int i = 0; i < acc0.size() && i < rsp0.size(); i++) begin
      chk("dut0_latency", 32'(rsp0[i]), 32'(acc0[i]));
      if (i > 0) chk("dut0_spacing", 32'(acc0[i] - acc0[i-1]), 32'd2);
    end

    // WAIT_CYCLES=3: out-of-range load answers four cycles after accept.
    @(negedge clk);
    r3_addr = 32'h0; r3_we = 0; r3_strb = 4'b1111; r3_req = 1;
    chk("dut3_ready", {31'b0, r3_ready}, 32'h1);
    acc3 = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    r3_req = 0;
    got3 = -1;
    for (int i = 0; i < 20 && got3 < 0; i++) begin
      if (r3_rv) begin
        got3 = cyc;
        $display("dut3 resp cyc=%0d err=%b rd=%h", cyc, r3_err, r3_rd);
        chk("dut3_err", {31'b0, r3_err}, 32'h1);
        chk("dut3_rd", r3_rd, 32'h0);
      end else begin
        @(negedge clk);
      end
    end
    chk("dut3_latency", 32'(got3), 32'(acc3 + 3));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the CPU's MemoryControl memory-communication interface (Addr, WD, WE, Strobe, RD).
- Accepts one load/store request at a time over a valid/ready handshake and performs byte-strobed writes into a word-organised RAM.
- Returns read data after a programmable number of wait states, with a one-cycle response pulse.
- Sits between MemoryControl and the on-chip data RAM; it is the first multi-cycle memory model the core will stall on.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM array.
- WAIT_CYCLES, 1: extra cycles between accept and response. Legal range 0..15.
- BASE_ADDR, 32'h0000_2000: byte address of word 0. Must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- Req  input  1  request valid from MemoryControl.
- Addr  input  32  byte address.
- WD  input  32  write data, already lane-aligned.
- WE  input  1  1 = store, 0 = load.
- Strobe  input  4  byte-lane enables; bit i covers WD[8i+7:8i].
- ReqReady  output  1  responder can accept a request.
- RD  output  32  read data, valid only while RespValid=1.
- RespValid  output  1  one-cycle response pulse.
- RespErr  output  1  error qualifier, valid only with RespValid.

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low, on rst_n.
- Reset values:
  - State goes to IDLE; ReqReady=1; RespValid=0; RespErr=0; RD=0; wait counter 0.
  - The RAM array is not reset.
- FSM states:
  - IDLE: ReqReady=1. On Req=1, latch Addr, WD, WE, Strobe.
    - Go to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go to RESP.
  - WAIT: ReqReady=0. Decrement the counter; go to RESP when it reaches 0.
  - RESP: ReqReady=0; RespValid=1 for exactly one cycle, then go to IDLE.
- Latency: the accept edge is cycle 0 and RespValid is high in cycle WAIT_CYCLES+1.
- Throughput: one transaction per WAIT_CYCLES+2 cycles. No acceptance during RESP.
- Address decode:
  - index = (Addr - BASE_ADDR) >> 2; Addr[1:0] is ignored.
  - In range: BASE_ADDR <= Addr < BASE_ADDR + 4*DEPTH_WORDS, using a 33-bit compare so the top of the address space cannot wrap.
- Store:
  - Lanes with Strobe[i]=1 are written on the edge entering RESP; other lanes are unchanged.
  - Strobe=0000 is a legal no-op.
  - RD=0 during a store response.
- Load:
  - RD is the full 32-bit word at index, sampled on the edge entering RESP. Strobe is ignored; MemoryControl extracts the bytes.
- Out of range:
  - No RAM write; RD=0; RespErr=1 in RESP.
- Inputs while ReqReady=0 are ignored and Req is not queued. The requester must hold Req until the accept edge.
- Reset mid-operation: the in-flight request is dropped, with no write and no response.
  - A store whose commit edge coincides with rst_n=0 is not committed.
- Read-after-write: a load accepted after a store's RESP cycle returns the updated word.

Optional Feature:
- Macro: DMEM_STROBE_CHECK_EN.
- Defined:
  - Legal store Strobe values are 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other non-zero value causes no write and RespErr=1.
  - Load strobes are not checked.
- Undefined: any Strobe is written as given and only the range check drives RespErr.

Decomposition:
- Shared package (e.g. mem_pkg):
  - FSM state enum (IDLE, WAIT, RESP).
  - Strobe constants (STRB_B0..STRB_B3, STRB_HLO, STRB_HHI, STRB_W).
  - WAIT counter width constant (4).
  - Legal-strobe function.
- One sub-module: dmem_bank, a DEPTH_WORDS x 32 synchronous RAM with per-byte write enable and registered read port, instantiated once. The FSM, decode and checks stay in dmem_responder.

Test Plan:
- Reset, then idle with WAIT_CYCLES=1 -> ReqReady=1, RespValid=0, RD=0.
- Store Addr=0x2004, WD=0xDEADBEEF, Strobe=1111, then load 0x2004 -> RespValid in cycle 2 of each transaction; the load returns RD=0xDEADBEEF and RespErr=0.
- Store Strobe=0010, WD=0x0000_5500 to 0x2004, then load -> RD=0xDEAD55EF.
- Load Addr=0x1FFC and Addr=0x3000 (DEPTH_WORDS=1024) -> RespErr=1, RD=0, RAM unchanged.
- WAIT_CYCLES=0 build, back-to-back Req held high for 3 requests -> accepts every 2 cycles, RespValid pulses one cycle after each accept. With WAIT_CYCLES=3 -> response at cycle 4.
- rst_n=0 during WAIT of a store of 0x12345678 -> no RespValid, word keeps its old value. With DMEM_STROBE_CHECK_EN, a store with Strobe=0101 -> RespErr=1, no write.
